// File: rtl/encoder_quad_gen_if.sv
// Step-command and quadrature-output bundle of the rotary encoder emulator.
// The master side issues step commands; the slave side is the generator.
interface encoder_quad_gen_if #(
    parameter int POS_W = 8
);
    logic             step_valid;
    logic             step_dir;
    logic             step_ready;
    logic             A;
    logic             B;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] pos;

    modport master (
        output step_valid, step_dir,
        input  step_ready, A, B, busy, done, pos
    );

    modport slave (
        input  step_valid, step_dir,
        output step_ready, A, B, busy, done, pos
    );
endinterface

// File: rtl/encoder_quad_gen.sv
// Emits one full A/B quadrature cycle per accepted step, emulating an EC11 detent,
// followed by an optional rest gap; tracks the resulting detent position.
module encoder_quad_gen #(
    parameter int PHASE_TICKS = 150_000,
    parameter int GAP_TICKS   = 150_000,
    parameter int POS_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    encoder_quad_gen_if.slave  bus
);
    localparam int MAX_TICKS = (PHASE_TICKS > GAP_TICKS) ? PHASE_TICKS : GAP_TICKS;
    localparam int TW        = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] P_LAST = TW'(PHASE_TICKS - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GAP_TICKS - 1);

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [POS_W-1:0]   pos_step_s;

    // Position after the step in flight completes; only committed on the edge entering IDLE.
    assign pos_step_s = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));

    // Next-state, phase timer and A/B pattern for each detent phase.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        a_d     = a_q;
        b_d     = b_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        pos_d   = pos_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (bus.step_valid) begin
                    state_d = PH1;
                    dir_d   = bus.step_dir;
                    a_d     = ~bus.step_dir;
                    b_d     = bus.step_dir;
                end else begin
                    state_d = IDLE;
                end
            end
            PH1: begin
                if (timer_q == P_LAST) begin
                    state_d = PH2;
                    timer_d = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    state_d = PH1;
                end
            end
            PH2: begin
                if (timer_q == P_LAST) begin
                    state_d = PH3;
                    timer_d = '0;
                    a_d     = dir_q;
                    b_d     = ~dir_q;
                end else begin
                    state_d = PH2;
                end
            end
            PH3: begin
                if (timer_q == P_LAST) begin
                    timer_d = '0;
                    a_d     = 1'b1;
                    b_d     = 1'b1;
                    // A zero-length gap returns straight to IDLE and completes here.
                    if (GAP_TICKS == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        pos_d   = pos_step_s;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    state_d = PH3;
                end
            end
            GAP: begin
                if (timer_q == G_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    done_d  = 1'b1;
                    pos_d   = pos_step_s;
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                a_d     = 1'b1;
                b_d     = 1'b1;
            end
        endcase
    end

    // State, timer and output flops; reset parks the outputs at rest immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            a_q     <= 1'b1;
            b_q     <= 1'b1;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
        end
    end

    assign bus.step_ready = (state_q == IDLE) && !rst;
    assign bus.busy       = (state_q != IDLE);
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.done       = done_q;
    assign bus.pos        = pos_q;
endmodule

// File: tb/tb_encoder_quad_gen.sv
// Randomised self-checking bench for encoder_quad_gen against a step-offset reference model.
module tb_encoder_quad_gen;
    localparam int P     = 4;
    localparam int G     = 2;
    localparam int TOTAL = 3 * P + G;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    encoder_quad_gen_if #(.POS_W(8)) bus ();

    encoder_quad_gen #(.PHASE_TICKS(P), .GAP_TICKS(G), .POS_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a step is just "cycles since handshake"; outputs follow from the offset.
    bit         m_active = 1'b0;
    bit         m_dir    = 1'b0;
    bit         m_done   = 1'b0;
    int         m_off    = 0;
    logic [7:0] m_pos    = 8'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_off    <= 0;
            m_pos    <= 8'd0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                m_off <= m_off + 1;
                if (m_off + 1 == TOTAL) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_pos    <= m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
                end
            end else if (bus.step_valid) begin
                m_active <= 1'b1;
                m_off    <= 0;
                m_dir    <= bus.step_dir;
            end
        end
    end

    function automatic logic [1:0] exp_ab();
        if (!m_active)     return 2'b11;
        if (m_off < P)     return m_dir ? 2'b01 : 2'b10;
        if (m_off < 2 * P) return 2'b00;
        if (m_off < 3 * P) return m_dir ? 2'b10 : 2'b01;
        return 2'b11;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.step_valid = 1'b0;
        bus.step_dir   = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.A, bus.B, bus.busy, bus.done, bus.step_ready} !== 5'b11000 || bus.pos !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: A,B,busy,done,ready=%b pos=%0d, required 11000 pos=0",
                     {bus.A, bus.B, bus.busy, bus.done, bus.step_ready}, bus.pos);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.step_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: ready=%b, required 1", bus.step_ready);
        end
    endtask

    task automatic test_single_step(input bit dir, input logic [7:0] pos_req);
        logic [1:0] req;
        int         done_at = -1;
        bus.step_dir   = dir;
        bus.step_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.step_valid = 1'b0;
            if (i < P)          req = dir ? 2'b01 : 2'b10;
            else if (i < 2 * P) req = 2'b00;
            else if (i < 3 * P) req = dir ? 2'b10 : 2'b01;
            else                req = 2'b11;
            n_checks++;
            if ({bus.A, bus.B} !== req) begin
                n_fail++;
                $display("FAIL step_dir%0d_ab offset %0d: AB=%b, required %b", dir, i, {bus.A, bus.B}, req);
            end
            if (bus.done === 1'b1 && done_at < 0) done_at = i;
        end
        n_checks++;
        if (done_at != TOTAL) begin
            n_fail++;
            $display("FAIL step_dir%0d_done_latency: %0d, required %0d", dir, done_at, TOTAL);
        end
        n_checks++;
        if (bus.pos !== pos_req) begin
            n_fail++;
            $display("FAIL step_dir%0d_pos: %0d, required %0d", dir, bus.pos, pos_req);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pos0 = m_pos;
        int dones = 0, rest_busy = 0, a_falls = 0, cycles = 0;
        logic prev_a = bus.A;
        bus.step_dir   = 1'b1;
        bus.step_valid = 1'b1;
        while (dones < 3 && cycles < 100) begin
            @(negedge clk);
            cycles++;
            n_checks++;
            if ({bus.A, bus.B} !== exp_ab()) begin
                n_fail++;
                $display("FAIL b2b_ab cycle %0d: AB=%b, required %b", cycles, {bus.A, bus.B}, exp_ab());
            end
            if (bus.busy && bus.A && bus.B) rest_busy++;
            if (prev_a && !bus.A && bus.B) a_falls++;
            prev_a = bus.A;
            if (bus.done === 1'b1) begin
                dones++;
                n_checks++;
                if (bus.step_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready_after_done: ready=%b, required 1", bus.step_ready);
                end
                if (dones == 3) bus.step_valid = 1'b0;
            end
        end
        n_checks++;
        if (dones != 3 || rest_busy != 3 * G || a_falls != 3) begin
            n_fail++;
            $display("FAIL b2b_counts: dones=%0d rest=%0d afalls=%0d, required 3 %0d 3", dones, rest_busy, 3 * G, a_falls);
        end
        n_checks++;
        if (bus.pos !== pos0 + 8'd3) begin
            n_fail++;
            $display("FAIL b2b_pos: %0d, required %0d", bus.pos, pos0 + 8'd3);
        end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] pos0 = m_pos;
        logic [1:0] req;
        int dones = 0;
        bus.step_dir   = 1'b1;
        bus.step_valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i < P)          req = 2'b01;
            else if (i < 2 * P) req = 2'b00;
            else if (i < 3 * P) req = 2'b10;
            else                req = 2'b11;
            n_checks++;
            if ({bus.A, bus.B} !== req) begin
                n_fail++;
                $display("FAIL ignore_busy_ab offset %0d: AB=%b, required %b", i, {bus.A, bus.B}, req);
            end
            if (bus.done === 1'b1) dones++;
            bus.step_dir   = $urandom_range(1, 0);
            bus.step_valid = (i < TOTAL - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
        end
        n_checks++;
        if (dones != 1 || bus.pos !== pos0 + 8'd1) begin
            n_fail++;
            $display("FAIL ignore_busy_done: dones=%0d pos=%0d, required 1 pos=%0d", dones, bus.pos, pos0 + 8'd1);
        end
    endtask

    task automatic test_reset_mid_step();
        int dones = 0;
        bus.step_dir   = 1'b1;
        bus.step_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.step_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.A, bus.B, bus.busy, bus.done, bus.step_ready} !== 5'b11000) begin
            n_fail++;
            $display("FAIL midstep_reset: A,B,busy,done,ready=%b, required 11000",
                     {bus.A, bus.B, bus.busy, bus.done, bus.step_ready});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.step_ready !== 1'b1 || bus.pos !== 8'd0 || {bus.A, bus.B} !== 2'b11) begin
            n_fail++;
            $display("FAIL midstep_release: ready=%b pos=%0d AB=%b, required 1 0 11", bus.step_ready, bus.pos, {bus.A, bus.B});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL midstep_no_done: dones=%0d, required 0", dones);
        end
    endtask

    task automatic test_wrap();
        int dones = 0, cycles = 0;
        bus.step_dir   = 1'b1;
        bus.step_valid = 1'b1;
        while (dones < 256 && cycles < 256 * (TOTAL + 1) + 50) begin
            @(negedge clk);
            cycles++;
            if (bus.done === 1'b1) begin
                dones++;
                if (dones == 255) begin
                    n_checks++;
                    if (bus.pos !== 8'd255) begin
                        n_fail++;
                        $display("FAIL wrap_pos255: %0d, required 255", bus.pos);
                    end
                end
                if (dones == 256) bus.step_valid = 1'b0;
            end
        end
        n_checks++;
        if (dones != 256 || bus.pos !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_pos0: dones=%0d pos=%0d, required 256 0", dones, bus.pos);
        end
    endtask

    task automatic test_random();
        logic [1:0] prev_ab = {bus.A, bus.B};
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.A, bus.B} !== exp_ab() || bus.busy !== m_active || bus.done !== m_done ||
                bus.pos !== m_pos || bus.step_ready !== !m_active) begin
                n_fail++;
                $display("FAIL random cycle %0d: AB=%b busy=%b done=%b pos=%0d ready=%b, required %b %b %b %0d %b",
                         i, {bus.A, bus.B}, bus.busy, bus.done, bus.pos, bus.step_ready,
                         exp_ab(), m_active, m_done, m_pos, !m_active);
            end
            n_checks++;
            if ((prev_ab[1] ^ bus.A) & (prev_ab[0] ^ bus.B)) begin
                n_fail++;
                $display("FAIL random_gray cycle %0d: AB %b -> %b, required single-bit change", i, prev_ab, {bus.A, bus.B});
            end
            prev_ab = {bus.A, bus.B};
            bus.step_valid = ($urandom_range(3, 0) == 0);
            bus.step_dir   = $urandom_range(1, 0);
        end
        bus.step_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_step(1'b1, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        test_single_step(1'b0, 8'hFF);
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_step();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
